mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 35 +++
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl_load_extend.sv | 26 ++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared core definitions for the data-memory access path: FSM encoding,
// req_size mode constants and small decode helpers.
package mem_access_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT2 = 1'b1
    } state_t;

    // req_size[1:0] access widths; 2'b11 is reserved and decoded as a word
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    // req_size[2] selects zero-extension of loads
    localparam int SIZE_UNSIGNED_BIT = 2;

    // Byte-lane mask of an access before it is shifted to its offset
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            SIZE_BYTE: size_mask = 4'b0001;
            SIZE_HALF: size_mask = 4'b0011;
            default:   size_mask = 4'b1111;
        endcase
    endfunction

    // An access is misaligned when its lanes cross a word boundary
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = (off == 2'b11);
            default:   is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle between the MEM stage / word memory (master) and the access
// controller (slave).
// Handshake: the MEM stage presents an access with req_valid=1. The access
// completes in the cycle resp_valid=1. While stall=1 the request fields must
// stay stable; stall=0 with resp_valid=1 means the pipeline may advance after
// this clock edge.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, mem_rdata,
        input  stall, resp_valid, resp_rdata, misalign_err,
               mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, mem_rdata,
        output stall, resp_valid, resp_rdata, misalign_err,
               mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Lane select plus sign/zero extension of load data. The aligned path feeds
// the raw memory word with its offset; the split path feeds the already
// merged word with offset 0.
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] rdata
);
    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    // Extend the selected lanes according to width and signedness
    always_comb begin
        case (size[1:0])
            SIZE_BYTE: rdata = size[SIZE_UNSIGNED_BIT] ? {24'b0, shifted[7:0]}
                                                       : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: rdata = size[SIZE_UNSIGNED_BIT] ? {16'b0, shifted[15:0]}
                                                       : {{16{shifted[15]}}, shifted[15:0]};
            default:   rdata = shifted;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: aligned accesses finish combinationally in
// one cycle; misaligned accesses are split into two word beats (SPLIT_EN=1)
// or rejected with a one-cycle misalign_err pulse (SPLIT_EN=0).
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus,
    output state_t             dbg_state
);
    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, lo_q;
    logic [2:0]  size_q;
    logic        we_q;
    logic        capture;

    // Beat 2 works only from the request latched at beat 1
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_size;
    logic        cur_we;
    logic [1:0]  off;
    logic        misaligned;
    logic [7:0]  strb8;
    logic [63:0] wdata64;
    logic [31:0] merged, ext_word, ext_rdata;
    logic [1:0]  ext_off;

    assign cur_addr   = (state_q == BEAT2) ? addr_q  : bus.req_addr;
    assign cur_wdata  = (state_q == BEAT2) ? wdata_q : bus.req_wdata;
    assign cur_size   = (state_q == BEAT2) ? size_q  : bus.req_size;
    assign cur_we     = (state_q == BEAT2) ? we_q    : bus.req_we;
    assign off        = cur_addr[1:0];
    assign misaligned = is_misaligned(cur_size[1:0], off);

    // Lanes and data spread over two words; low half is beat 1, high half beat 2
    assign strb8   = {4'b0000, size_mask(cur_size[1:0])} << off;
    assign wdata64 = {32'b0, cur_wdata} << {off, 3'b000};
    assign merged  = 32'({bus.mem_rdata, lo_q} >> {off, 3'b000});

    assign ext_word = (state_q == BEAT2) ? merged : bus.mem_rdata;
    assign ext_off  = (state_q == BEAT2) ? 2'b00  : off;

    load_extend u_load_extend (
        .word   (ext_word),
        .offset (ext_off),
        .size   (cur_size),
        .rdata  (ext_rdata)
    );

    assign dbg_state = state_q;

    // State register and beat-1 request/read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                we_q    <= bus.req_we;
                lo_q    <= bus.mem_rdata;
            end
        end
    end

    // Next state and all bus outputs; reset forces the bus quiet
    always_comb begin
        state_d          = state_q;
        capture          = 1'b0;
        bus.stall        = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = ext_rdata;
        bus.misalign_err = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = {cur_addr[31:2], 2'b00};
        bus.mem_wstrb    = 4'b0000;
        bus.mem_wdata    = wdata64[31:0];
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!misaligned) begin
                        bus.resp_valid = 1'b1;
                        bus.mem_we     = cur_we;
                        bus.mem_wstrb  = strb8[3:0];
                    end else if (SPLIT_EN) begin
                        bus.stall     = 1'b1;
                        bus.mem_we    = cur_we;
                        bus.mem_wstrb = strb8[3:0];
                        capture       = 1'b1;
                        state_d       = BEAT2;
                    end else begin
                        bus.resp_valid   = 1'b1;
                        bus.misalign_err = 1'b1;
                        bus.resp_rdata   = '0;
                    end
                end
            end
            BEAT2: begin
                bus.mem_addr   = {cur_addr[31:2], 2'b00} + 32'd4;
                bus.mem_we     = cur_we;
                bus.mem_wstrb  = strb8[7:4];
                bus.mem_wdata  = wdata64[63:32];
                bus.resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            bus.stall        = 1'b0;
            bus.resp_valid   = 1'b0;
            bus.misalign_err = 1'b0;
            bus.mem_we       = 1'b0;
            bus.mem_wstrb    = 4'b0000;
        end
    end
endmodule
